// File: rtl/signed_arith_bcd_seq_pkg.sv
// Shared definitions for the sign-magnitude BCD calculator:
// op codes, FSM state encoding, BCD digit width and a power-of-ten helper.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_CONV = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int BCD_W = 4;

    // 10^n, used to detect magnitudes that do not fit in the digit field
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/signed_arith_bcd_seq_bin2bcd.sv
// Sequential double-dabble converter: R-bit binary in, ND BCD digits out.
// The first shift happens on the load edge, so a result is ready R cycles
// after start (done is high while the finished value is presented).
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int R  = 8,
    parameter int ND = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [R-1:0]          bin,
    output logic                  done,
    output logic [BCD_W*ND-1:0]   bcd
);

    localparam int DW = BCD_W * ND;
    localparam int CW = $clog2(R + 1);

    logic [R-1:0]  bin_q;
    logic [DW-1:0] bcd_q;
    logic [DW-1:0] adj_w;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    // add-3 correction on every digit that would overflow when doubled
    for (genvar gi = 0; gi < ND; gi++) begin : g_adj
        assign adj_w[gi*BCD_W +: BCD_W] = (bcd_q[gi*BCD_W +: BCD_W] >= 4'd5) ?
                                          bcd_q[gi*BCD_W +: BCD_W] + 4'd3 :
                                          bcd_q[gi*BCD_W +: BCD_W];
    end

    // load with the first shift applied, then shift one bit per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            bin_q  <= bin << 1;
            bcd_q  <= DW'(bin[R-1]);
            cnt_q  <= CW'(R - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                bcd_q <= {adj_w[DW-2:0], bin_q[R-1]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/signed_arith_bcd_seq.sv
// Sequential sign-magnitude calculator with BCD result.
// IDLE -> CALC (add/sub 1 cycle, mul/div W+1 cycles) -> CONV (2W cycles) -> DONE.
// Optional divider: define DIV_EN to build the restoring divider for op 11;
// otherwise op 11 reports err with a zero result at add/sub latency.
module signed_arith_bcd_seq
    import calc_pkg::*;
#(
    parameter int W  = 4,
    parameter int ND = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [W-1:0]        x_mag,
    input  logic                x_sign,
    input  logic [W-1:0]        y_mag,
    input  logic                y_sign,
    output logic                busy,
    output logic                done,
    output logic                res_sign,
    output logic [4*ND-1:0]     digits,
    output logic                err
);

    localparam int R  = 2 * W;
    localparam int CW = $clog2(W + 2);
    localparam logic [63:0] LIMIT = 64'(pow10(ND));

    state_e         state_q;
    op_e            op_q;
    logic [W-1:0]   xm_q, ym_q;
    logic           xs_q, ys_q;
    logic [CW-1:0]  cnt_q;
    logic [R-1:0]   acc_q;
    logic [R-1:0]   mcand_q;
    logic [W-1:0]   mplr_q;      // multiplier bits, or dividend/quotient bits when dividing
    logic           calc_sign_q, calc_err_q, calc_sat_q;
    logic           busy_q, done_q, res_sign_q, err_q;
    logic [4*ND-1:0] digits_q;

    logic           fin_d;
    logic [R-1:0]   mag_d;
    logic           sign_d, err_d, ovf_d, eff_ys;
    logic [W:0]     sum_w;
    logic           bcd_done;
    logic [4*ND-1:0] bcd_w;

`ifdef DIV_EN
    logic [W-1:0]   rem_q;
    logic [W:0]     rem_sh, trial;

    // one restoring-division step: shift in next dividend bit, try to subtract
    always_comb begin
        rem_sh = {rem_q, mplr_q[W-1]};
        trial  = rem_sh - {1'b0, ym_q};
    end
`endif

    // decide whether CALC finishes this cycle and what magnitude/sign it yields
    always_comb begin
        fin_d  = 1'b0;
        mag_d  = '0;
        sign_d = 1'b0;
        err_d  = 1'b0;
        sum_w  = '0;
        eff_ys = ys_q ^ (op_q == OP_SUB);
        if (state_q == S_CALC) begin
            unique case (op_q)
                OP_ADD, OP_SUB: begin
                    fin_d = 1'b1;
                    if (xs_q == eff_ys) begin
                        sum_w  = {1'b0, xm_q} + {1'b0, ym_q};
                        sign_d = xs_q;
                    end else if (xm_q >= ym_q) begin
                        sum_w  = {1'b0, xm_q - ym_q};
                        sign_d = xs_q;
                    end else begin
                        sum_w  = {1'b0, ym_q - xm_q};
                        sign_d = eff_ys;
                    end
                    mag_d = R'(sum_w);
                end
                OP_MUL: begin
                    if (cnt_q == CW'(W)) begin
                        fin_d  = 1'b1;
                        mag_d  = acc_q;
                        sign_d = xs_q ^ ys_q;
                    end
                end
                OP_DIV: begin
`ifdef DIV_EN
                    if (ym_q == '0) begin
                        fin_d = 1'b1;
                        err_d = 1'b1;
                    end else if (cnt_q == CW'(W)) begin
                        fin_d  = 1'b1;
                        mag_d  = R'(mplr_q);
                        sign_d = xs_q ^ ys_q;
                    end
`else
                    fin_d = 1'b1;
                    err_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign ovf_d = (64'(mag_d) >= LIMIT);

    bin2bcd_seq #(
        .R  (R),
        .ND (ND)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (fin_d),
        .bin   (mag_d),
        .done  (bcd_done),
        .bcd   (bcd_w)
    );

    // control FSM, iterative datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            xm_q        <= '0;
            ym_q        <= '0;
            xs_q        <= 1'b0;
            ys_q        <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            calc_sign_q <= 1'b0;
            calc_err_q  <= 1'b0;
            calc_sat_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_sign_q  <= 1'b0;
            err_q       <= 1'b0;
            digits_q    <= '0;
`ifdef DIV_EN
            rem_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        xm_q    <= x_mag;
                        ym_q    <= y_mag;
                        xs_q    <= x_sign;
                        ys_q    <= y_sign;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        mcand_q <= R'(x_mag);
                        mplr_q  <= (op == OP_DIV) ? x_mag : y_mag;
`ifdef DIV_EN
                        rem_q   <= '0;
`endif
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (fin_d) begin
                        calc_sign_q <= sign_d && (mag_d != '0);
                        calc_err_q  <= err_d || ovf_d;
                        calc_sat_q  <= ovf_d;
                        state_q     <= S_CONV;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (op_q == OP_MUL) begin
                            if (mplr_q[0]) begin
                                acc_q <= acc_q + mcand_q;
                            end
                            mcand_q <= mcand_q << 1;
                            mplr_q  <= mplr_q >> 1;
                        end
`ifdef DIV_EN
                        else begin
                            if (!trial[W]) begin
                                rem_q <= trial[W-1:0];
                            end else begin
                                rem_q <= rem_sh[W-1:0];
                            end
                            mplr_q <= (mplr_q << 1) | W'(!trial[W]);
                        end
`endif
                    end
                end
                S_CONV: begin
                    if (bcd_done) begin
                        digits_q   <= calc_sat_q ? {ND{4'h9}} : bcd_w;
                        res_sign_q <= calc_sign_q;
                        err_q      <= calc_err_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_sign = res_sign_q;
    assign digits   = digits_q;
    assign err      = err_q;

endmodule
